b2g_arbiter: RTL

- Sequences and shares one combinational binary-to-Gray converter (b_to_g) among 4 requesters.
- Accepts one binary request at a time using round-robin arbitration and drives the request onto the shared converter.
- Captures the Gray result and returns it with the requester ID over a valid/ready response channel.
- Self-checks the converter against g = b ^ (b >> 1) and flags any mismatch with a sticky error bit.

---
 rtl/b2g_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/b2g_arbiter.sv
// b2g_arbiter: round-robin sharing of one external binary-to-Gray converter
// among four requesters. The block grants one request, drives the converter,
// captures its Gray result and returns it with the requester id. It also
// checks every conversion against an internal reference and keeps a sticky
// error flag when they disagree.
module b2g_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req_valid,
    input  logic [4*WIDTH-1:0]   req_bin,
    output logic [3:0]           req_ready,
    output logic [WIDTH-1:0]     conv_b,
    input  logic [WIDTH-1:0]     conv_g,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_id,
    output logic [WIDTH-1:0]     rsp_gray,
    input  logic                 rsp_ready,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q;
    logic [1:0]         ptr_q;
    logic [WIDTH-1:0]   conv_b_q;
    logic [1:0]         rsp_id_q;
    logic [WIDTH-1:0]   rsp_gray_q;
    logic               rsp_valid_q;
    logic               err_q;

    logic               grant_vld_s;
    logic [1:0]         grant_idx_s;

    // Reference Gray encoding used to cross-check the shared converter.
    function automatic logic [WIDTH-1:0] gray_ref(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Round-robin search: first asserted request starting at ptr_q, wrapping mod 4.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = 2'd0;
        // Walk from the farthest candidate down so the nearest one wins.
        for (int k = 3; k >= 0; k--) begin
            logic [1:0] cand;
            cand = ptr_q + 2'(k);
            if (req_valid[cand]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand;
            end else begin
                grant_vld_s = grant_vld_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // Accept pulse: one-hot on the winner, only while idle and out of reset.
    always_comb begin
        req_ready = 4'b0000;
        if ((state_q == ST_IDLE) && grant_vld_s && rst_n) begin
            req_ready = 4'b0001 << grant_idx_s;
        end else begin
            req_ready = 4'b0000;
        end
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            conv_b_q    <= {WIDTH{1'b0}};
            rsp_id_q    <= 2'd0;
            rsp_gray_q  <= {WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        conv_b_q <= req_bin[grant_idx_s*WIDTH +: WIDTH];
                        rsp_id_q <= grant_idx_s;
                        ptr_q    <= grant_idx_s + 2'd1;
                        state_q  <= ST_CONV;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    // The converter has had a full cycle to settle on conv_b.
                    rsp_gray_q  <= conv_g;
                    err_q       <= err_q | (conv_g != gray_ref(conv_b_q));
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign conv_b    = conv_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gray  = rsp_gray_q;
    assign err       = err_q;

endmodule
